icap_reboot_sequencer: RTL
==========================

// Module: icap_reboot_sequencer
// PURPOSE
//  Consumes the one-cycle reboot strobe produced by the top level's Ctrl+F2 edge detector.
//  On that strobe it drives the Spartan-6 ICAP port with the IPROG command stream.
//  The stream makes the FPGA reload a second core from the SPI flash at a runtime-selected address.
//  It replaces the opaque multiboot instance.
//  It sits between the top-level reboot_ff logic and the ICAP_SPARTAN6 primitive, in the clk14 domain.
// PARAMETERS
//  GOLDEN_ADDR  24'h000000  fallback flash address, written to GENERAL3/GENERAL4
//  SPI_OPCODE   8'h0B       flash read opcode, placed in GENERAL2[15:8] and GENERAL4[15:8]
//  PRE_DELAY    16          idle cycles between an accepted trigger and the first ICAP word (1..65535)
//  BITSWAP      1           1: reverse bit order within each byte of icap_din (ICAP convention)
// PORTS
//  clk        in   1   system clock (clk14)
//  rst        in   1   synchronous, active-high reset
//  reboot     in   1   one-cycle trigger strobe
//  boot_addr  in   24  flash byte address of the core to load; sampled on the trigger
//  icap_ce_n  out  1   ICAP chip enable, active low
//  icap_we_n  out  1   ICAP write (RDWRB), low = write
//  icap_din   out  16  ICAP data word
//  busy       out  1   high from an accepted trigger until reset
// BEHAVIOUR
//  Clocking and outputs:
//  - Single clock domain; all outputs are registered.
//  - Reset gives: icap_ce_n=1, icap_we_n=1, icap_din=16'hFFFF, busy=0, state IDLE, counters 0.
//  - Reset is honoured in every state, including mid-stream; the next cycle is IDLE with the reset values.
//  States:
//  - IDLE: reboot=1 at edge k latches boot_addr, loads the delay counter with PRE_DELAY-1, sets busy=1, goes to WAIT.
//  - WAIT: decrements the counter. At 0 it goes to SEND with word index 0.
//  - SEND: on each edge drives icap_ce_n=0, icap_we_n=0, icap_din=W[idx], then idx+1.
//    After W[13] is driven it goes to DONE.
//  - DONE: icap_ce_n=1, icap_we_n=1, icap_din=16'hFFFF, busy stays 1. It leaves DONE only on rst.
//  - reboot is ignored in WAIT, SEND and DONE. There is no queueing or restart.
//  Timing: with PRE_DELAY=N, word 0 appears at edge k+N+1 and word 13 at edge k+N+14.
//    icap_ce_n is low for exactly 14 consecutive cycles.
//  Word table (A = latched boot_addr, G = GOLDEN_ADDR, O = SPI_OPCODE):
//   0 FFFF   1 AA99   2 5566   3 3261   4 A[15:0]    5 3281   6 {O,A[23:16]}
//   7 32A1   8 G[15:0]   9 32C1   10 {O,G[23:16]}   11 30A1   12 000E   13 2000
//  BITSWAP=1: icap_din[15:8] = bitrev(W[15:8]) and icap_din[7:0] = bitrev(W[7:0]).
//    This is applied to every word, including table constants; 16'hFFFF idle is unaffected.
//  A change on boot_addr after edge k does not affect the stream.
//  A trigger in the same cycle as rst is discarded (reset wins).
// TESTING
//  1 Reset: hold rst 3 cycles, reboot=0 -> ce_n=1, we_n=1, din=FFFF, busy=0.
//    Steady for 100 cycles.
//  2 BITSWAP=0, PRE_DELAY=4, boot_addr=24'h058000, one-cycle reboot
//    -> busy at k+1, word 0 at k+5.
//    Stream: FFFF,AA99,5566,3261,8000,3281,0B05,32A1,0000,32C1,0B00,30A1,000E,2000.
//    Then ce_n=1.
//  3 BITSWAP=1, same stimulus -> words 0..3 are FFFF,5599,AA66,4C86.
//    Word 4 (8000) -> 0100.
//  4 Second reboot pulse during SEND and one during DONE -> stream unchanged.
//    Stays in DONE with busy=1 and ce_n=1.
//  5 Change boot_addr to 24'h0A0000 one cycle after the trigger -> word 6 is still 0B05.
//  6 Assert rst while word 7 is driven -> next cycle ce_n=1 and busy=0.
//    A new trigger with boot_addr=24'h0A0000 restarts from word 0; word 6 = 0B0A.

Source files
------------

// File: rtl/icap_reboot_sequencer.sv
// Drives the Spartan-6 ICAP with an IPROG command stream after a reboot strobe,
// so the FPGA reloads a core from SPI flash at a runtime-selected address.
module icap_reboot_sequencer #(
    parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
    parameter logic [7:0]  SPI_OPCODE  = 8'h0B,
    parameter int          PRE_DELAY   = 16,
    parameter bit          BITSWAP     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reboot,
    input  logic [23:0] boot_addr,
    output logic        icap_ce_n,
    output logic        icap_we_n,
    output logic [15:0] icap_din,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [15:0] DELAY_LOAD = 16'(PRE_DELAY - 1);
    localparam logic [3:0]  LAST_WORD  = 4'd13;

    logic [1:0]  state;
    logic [15:0] delay_cnt;
    logic [3:0]  word_idx;
    logic [23:0] addr_q;
    logic [15:0] word_raw;
    logic [15:0] word_out;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    // IPROG sequence: sync, WBSTAR/GENERAL1-4 load, then the IPROG command
    always_comb begin
        word_raw = 16'hFFFF;
        case (word_idx)
            4'd0:    word_raw = 16'hFFFF;
            4'd1:    word_raw = 16'hAA99;
            4'd2:    word_raw = 16'h5566;
            4'd3:    word_raw = 16'h3261;
            4'd4:    word_raw = addr_q[15:0];
            4'd5:    word_raw = 16'h3281;
            4'd6:    word_raw = {SPI_OPCODE, addr_q[23:16]};
            4'd7:    word_raw = 16'h32A1;
            4'd8:    word_raw = GOLDEN_ADDR[15:0];
            4'd9:    word_raw = 16'h32C1;
            4'd10:   word_raw = {SPI_OPCODE, GOLDEN_ADDR[23:16]};
            4'd11:   word_raw = 16'h30A1;
            4'd12:   word_raw = 16'h000E;
            4'd13:   word_raw = 16'h2000;
            default: word_raw = 16'hFFFF;
        endcase
    end

    always_comb begin
        word_out = word_raw;
        if (BITSWAP) begin
            word_out = {bitrev8(word_raw[15:8]), bitrev8(word_raw[7:0])};
        end
    end

    // One-shot sequencer: once triggered it only leaves DONE through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            delay_cnt <= 16'd0;
            word_idx  <= 4'd0;
            addr_q    <= 24'd0;
            icap_ce_n <= 1'b1;
            icap_we_n <= 1'b1;
            icap_din  <= 16'hFFFF;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reboot) begin
                        addr_q    <= boot_addr;
                        delay_cnt <= DELAY_LOAD;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (delay_cnt == 16'd0) begin
                        word_idx <= 4'd0;
                        state    <= ST_SEND;
                    end else begin
                        delay_cnt <= delay_cnt - 16'd1;
                    end
                end
                ST_SEND: begin
                    icap_ce_n <= 1'b0;
                    icap_we_n <= 1'b0;
                    icap_din  <= word_out;
                    if (word_idx == LAST_WORD) begin
                        state <= ST_DONE;
                    end else begin
                        word_idx <= word_idx + 4'd1;
                    end
                end
                ST_DONE: begin
                    icap_ce_n <= 1'b1;
                    icap_we_n <= 1'b1;
                    icap_din  <= 16'hFFFF;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
